// File: rtl/ifetch_pq.sv
// Decoupled instruction fetch: valid/ready imem requests, in-order responses, a
// DEPTH-entry prefetch queue and the IF/ID register with stall/flush/redirect.
module ifetch_pq #(
  parameter int               XLEN     = 32,
  parameter int               ILEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [ILEN-1:0]  NOP      = ILEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ImemReqValid,
  input  logic            ImemReqReady,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemRspValid,
  input  logic [ILEN-1:0] ImemRspData,
  output logic [ILEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pcf_p0;
  logic [CW-1:0]   ocnt;
  logic [CW-1:0]   dcnt;
  logic [CW-1:0]   qcnt;
  logic [AW-1:0]   qwr, qrd;
  logic [AW-1:0]   swr, srd;

  logic [XLEN-1:0] spc  [DEPTH];
  logic [XLEN-1:0] qpc  [DEPTH];
  logic [ILEN-1:0] qins [DEPTH];

  logic [CW:0] inflight;
  logic        credit;
  logic        issue;
  logic        rsp_ok;
  logic        rsp_keep;
  logic        rsp_drop;
  logic        pop;

  // Credit covers both requests in flight and entries already buffered, so
  // every accepted request is guaranteed a queue slot when it returns.
  assign inflight     = {1'b0, ocnt} + {1'b0, qcnt};
  assign credit       = inflight < (CW+1)'(DEPTH);
  assign ImemReqValid = !reset && !PCSrcE && credit;
  assign ImemAddr     = pcf_p0;
  assign issue        = ImemReqValid && ImemReqReady;

  // Responses with nothing outstanding (e.g. from before a reset) are ignored.
  assign rsp_ok   = ImemRspValid && (ocnt != '0);
  assign rsp_keep = rsp_ok && !PCSrcE && (dcnt == '0);
  assign rsp_drop = rsp_ok && !PCSrcE && (dcnt != '0);
  assign pop      = !PCSrcE && !FlushD && !StallD && (qcnt != '0);

  // ---- fetch stage: PC, credits, side FIFO and queue bookkeeping ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_p0 <= RESET_PC;
      ocnt   <= '0;
      dcnt   <= '0;
      qcnt   <= '0;
      qwr    <= '0;
      qrd    <= '0;
      swr    <= '0;
      srd    <= '0;
    end else begin
      ocnt <= ocnt + CW'(issue) - CW'(rsp_ok);
      if (PCSrcE) begin
        pcf_p0 <= PCTargetE;
        dcnt   <= ocnt - CW'(rsp_ok);
        qcnt   <= '0;
        qwr    <= '0;
        qrd    <= '0;
        swr    <= '0;
        srd    <= '0;
      end else begin
        if (issue) begin
          pcf_p0 <= pcf_p0 + XLEN'(4);
          swr    <= swr + AW'(1);
        end
        if (rsp_drop)
          dcnt <= dcnt - CW'(1);
        if (rsp_keep) begin
          qwr <= qwr + AW'(1);
          srd <= srd + AW'(1);
        end
        if (pop)
          qrd <= qrd + AW'(1);
        qcnt <= qcnt + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (issue)
      spc[swr] <= pcf_p0;
    if (rsp_keep) begin
      qpc[qwr]  <= spc[srd];
      qins[qwr] <= ImemRspData;
    end
  end

  // ---- decode stage: IF/ID register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ValidD   <= 1'b0;
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
    end else if (PCSrcE || FlushD) begin
      ValidD <= 1'b0;
      InstrD <= NOP;
    end else if (StallD) begin
      ValidD   <= ValidD;
      InstrD   <= InstrD;
      PCD      <= PCD;
      PCPlus4D <= PCPlus4D;
    end else if (qcnt != '0) begin
      ValidD   <= 1'b1;
      InstrD   <= qins[qrd];
      PCD      <= qpc[qrd];
      PCPlus4D <= qpc[qrd] + XLEN'(4);
    end else begin
      ValidD <= 1'b0;
      InstrD <= NOP;
    end
  end

endmodule
